mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Parameters
REQ-001 The block SHALL take these parameters, one per line: name, default, meaning.
- MAX_BURST, 8, maximum consecutive grants to one owner while the other requester waits
- ADDR_W, 16, memory word-address width
- DATA_W, 32, memory data width; byte enables are DATA_W/8 bits wide

Interface
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge
- rst, in, 1, synchronous reset, active-high
- i_core_req, in, 1, downscaler controller requests one memory transaction
- i_core_we, in, 1, 1 = write, 0 = read
- i_core_addr, in, ADDR_W, word address
- i_core_be, in, 4, byte enables
- i_core_wdata, in, DATA_W, write data
- o_core_gnt, out, 1, transaction issued this cycle
- o_core_rvalid, out, 1, read data valid for core
- o_core_rdata, out, DATA_W, read data for core
- i_host_req, in, 1, host loader/readback request
- i_host_we, in, 1, host write enable
- i_host_addr, in, ADDR_W, host word address
- i_host_be, in, 4, host byte enables
- i_host_wdata, in, DATA_W, host write data
- i_host_lock, in, 1, host exclusive-ownership request
- o_host_gnt, out, 1, host transaction issued this cycle
- o_host_rvalid, out, 1, read data valid for host
- o_host_rdata, out, DATA_W, read data for host
- o_mem_addr, out, ADDR_W, shared memory address
- o_mem_we, out, 1, shared write strobe
- o_mem_byte_en, out, 4, shared byte enables
- o_mem_wdata, out, DATA_W, shared write data
- i_mem_rdata, in, DATA_W, memory read data; one-cycle read latency
- o_owner, out, 2, owner state: 00 IDLE, 01 CORE, 10 HOST
- o_conflict_cnt, out, 16, number of cycles in which a requesting port was refused

Function
REQ-003 Owner FSM states SHALL be IDLE, CORE and HOST; the state register holds the previous cycle's grantee.
REQ-004 At most one grant SHALL be asserted per cycle.
- A grant is combinational in the cycle of the request.
- Each grant issues exactly one transaction on the memory port in that cycle.
REQ-005 Grant selection each cycle SHALL apply these rules in order.
- (a) i_host_lock and i_host_req both high: grant host; burst limit ignored.
- (b) Only one requester active: grant it.
- (c) Both active and the current owner's burst_cnt < MAX_BURST-1: grant the current owner.
- (d) Both active otherwise: grant the non-owner; from IDLE, grant the requester not served last (rr_last; core first after reset).
REQ-006 Next-state rules SHALL be as follows.
- The FSM moves to the granted requester's state.
- With no grant, it moves to IDLE and burst_cnt returns to 0.
REQ-007 burst_cnt SHALL behave as follows.
- It increments when the same requester is granted in consecutive cycles.
- It resets to 0 on an owner change.
- It saturates at MAX_BURST-1.
REQ-008 rr_last SHALL update to the granted requester on every grant.
REQ-009 On a grant, the memory outputs SHALL follow the granted requester's fields, with o_mem_we equal to that requester's we.
REQ-010 With no grant, o_mem_we SHALL be 0 and o_mem_addr, o_mem_byte_en and o_mem_wdata SHALL be 0.
REQ-011 A read (we=0) granted in cycle N SHALL return data as follows.
- The requester's rvalid is a registered pulse in cycle N+1.
- Its rdata equals i_mem_rdata in cycle N+1.
- The other port's rvalid stays 0.
REQ-012 o_core_rdata and o_host_rdata SHALL both carry i_mem_rdata combinationally; only rvalid qualifies them.
REQ-013 Writes SHALL produce no rvalid.
REQ-014 o_conflict_cnt SHALL count refusals as follows.
- It increments by 1 in any cycle where a requester has req=1 and gnt=0.
- It saturates at 16'hFFFF.
REQ-015 A requester SHALL hold its req and fields stable until it sees gnt.
- The arbiter keeps no request buffering.
- It evaluates requests fresh every cycle.
REQ-016 Back-to-back reads from alternating requesters SHALL each receive their own rvalid with no lost or swapped responses.

Reset
REQ-017 While rst=1, the following SHALL hold.
- State = IDLE, burst_cnt = 0, rr_last = host (so core wins the first tie), o_conflict_cnt = 0.
- Both gnt and both rvalid are 0.
- All memory outputs are 0.
REQ-018 A read granted in the cycle before rst is asserted SHALL produce no rvalid after reset.
REQ-019 In the first cycle after rst deasserts, arbitration SHALL resume per REQ-005.

Verification
REQ-020 The bench SHALL cover these directed scenarios, with MAX_BURST=4.
- Core-only read to addr 0x0010, mem returns 0xA1B2C3D4 -> o_core_gnt in cycle N, o_core_rvalid=1 with rdata 0xA1B2C3D4 in N+1, o_host_rvalid=0.
- Both request continuously from IDLE after reset -> grant sequence CORE×4, HOST×4, CORE×4; o_conflict_cnt increments once per cycle.
- Host write (addr 0x4000, be 4'b0100, wdata 0x00FF0000) with i_host_lock=1 while core requests for 10 cycles -> host granted all 10 cycles, o_mem_we=1, core refused, o_conflict_cnt=10.
- Alternating single-cycle reads core@0x0001, host@0x0002, core@0x0003 -> rvalid pulses core, host, core in successive cycles, each matching the mem data of that cycle.
- Read granted in cycle N, rst=1 in N+1 -> no rvalid in N+1; all outputs 0; o_owner=00.
- Force o_conflict_cnt to 0xFFFE, then 3 refused cycles -> value holds at 0xFFFF.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: the downscaler core and the host loader share one
// single-cycle memory port. Grants are combinational. A burst limit keeps either
// side from starving the other, and the host can take exclusive ownership with a lock.
module mem_port_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_core_req,
  input  logic                i_core_we,
  input  logic [ADDR_W-1:0]   i_core_addr,
  input  logic [DATA_W/8-1:0] i_core_be,
  input  logic [DATA_W-1:0]   i_core_wdata,
  output logic                o_core_gnt,
  output logic                o_core_rvalid,
  output logic [DATA_W-1:0]   o_core_rdata,
  input  logic                i_host_req,
  input  logic                i_host_we,
  input  logic [ADDR_W-1:0]   i_host_addr,
  input  logic [DATA_W/8-1:0] i_host_be,
  input  logic [DATA_W-1:0]   i_host_wdata,
  input  logic                i_host_lock,
  output logic                o_host_gnt,
  output logic                o_host_rvalid,
  output logic [DATA_W-1:0]   o_host_rdata,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_we,
  output logic [DATA_W/8-1:0] o_mem_byte_en,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic [1:0]          o_owner,
  output logic [15:0]         o_conflict_cnt
);

  localparam int CNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] BURST_TOP = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE = 2'b00, CORE = 2'b01, HOST = 2'b10} owner_e;

  owner_e           state_q, state_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             rr_last_q;          // 1 = host was served most recently
  logic             core_rv_q, host_rv_q;
  logic [15:0]      conflict_q;
  logic             core_gnt, host_gnt, refused;

  // Grant selection: lock, then sole requester, then burst/owner, then round-robin from IDLE
  always_comb begin
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    if (!rst) begin
      if (i_host_lock && i_host_req)    host_gnt = 1'b1;
      else if (i_core_req && !i_host_req) core_gnt = 1'b1;
      else if (i_host_req && !i_core_req) host_gnt = 1'b1;
      else if (i_core_req && i_host_req) begin
        case (state_q)
          CORE:    if (burst_q < BURST_TOP) core_gnt = 1'b1; else host_gnt = 1'b1;
          HOST:    if (burst_q < BURST_TOP) host_gnt = 1'b1; else core_gnt = 1'b1;
          default: if (rr_last_q) core_gnt = 1'b1; else host_gnt = 1'b1;
        endcase
      end
    end
  end

  // Next owner and burst length: count only repeat grants to the same side
  always_comb begin
    state_d = IDLE;
    burst_d = '0;
    if (core_gnt) state_d = CORE;
    else if (host_gnt) state_d = HOST;
    if ((core_gnt && state_q == CORE) || (host_gnt && state_q == HOST))
      burst_d = (burst_q == BURST_TOP) ? burst_q : burst_q + 1'b1;
  end

  assign refused = (i_core_req && !core_gnt) || (i_host_req && !host_gnt);

  // Owner FSM, round-robin memory, read-response tags and refusal counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      burst_q    <= '0;
      rr_last_q  <= 1'b1;
      core_rv_q  <= 1'b0;
      host_rv_q  <= 1'b0;
      conflict_q <= '0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      if (core_gnt)      rr_last_q <= 1'b0;
      else if (host_gnt) rr_last_q <= 1'b1;
      core_rv_q <= core_gnt && !i_core_we;
      host_rv_q <= host_gnt && !i_host_we;
      if (refused && conflict_q != 16'hFFFF) conflict_q <= conflict_q + 16'd1;
    end
  end

  // Shared memory port follows the granted side; idle drives zeros
  always_comb begin
    o_mem_addr    = '0;
    o_mem_we      = 1'b0;
    o_mem_byte_en = '0;
    o_mem_wdata   = '0;
    if (core_gnt) begin
      o_mem_addr    = i_core_addr;
      o_mem_we      = i_core_we;
      o_mem_byte_en = i_core_be;
      o_mem_wdata   = i_core_wdata;
    end else if (host_gnt) begin
      o_mem_addr    = i_host_addr;
      o_mem_we      = i_host_we;
      o_mem_byte_en = i_host_be;
      o_mem_wdata   = i_host_wdata;
    end
  end

  // Reset is visible in the same cycle it is asserted, so a response in flight
  // when rst rises is dropped rather than leaking out.
  assign o_core_gnt     = core_gnt;
  assign o_host_gnt     = host_gnt;
  assign o_core_rvalid  = core_rv_q && !rst;
  assign o_host_rvalid  = host_rv_q && !rst;
  assign o_core_rdata   = rst ? '0 : i_mem_rdata;
  assign o_host_rdata   = rst ? '0 : i_mem_rdata;
  assign o_owner        = rst ? IDLE : state_q;
  assign o_conflict_cnt = rst ? 16'd0 : conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MAX_BURST=4): vector table for
// single transactions and reset, hand sequences for bursts, lock and saturation.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam logic [3:0]  CBE = 4'hF;
  localparam logic [31:0] CWD = 32'hC0C0C0C0;

  logic clk = 1'b0;
  logic rst;
  logic core_req, core_we, core_gnt, core_rvalid;
  logic [AW-1:0] core_addr;
  logic [3:0] core_be;
  logic [DW-1:0] core_wdata, core_rdata;
  logic host_req, host_we, host_lock, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [3:0] host_be;
  logic [DW-1:0] host_wdata, host_rdata;
  logic [AW-1:0] mem_addr;
  logic mem_we;
  logic [3:0] mem_be;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0] owner;
  logic [15:0] conflict;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_BURST(4), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_core_req(core_req), .i_core_we(core_we), .i_core_addr(core_addr),
    .i_core_be(core_be), .i_core_wdata(core_wdata),
    .o_core_gnt(core_gnt), .o_core_rvalid(core_rvalid), .o_core_rdata(core_rdata),
    .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr),
    .i_host_be(host_be), .i_host_wdata(host_wdata), .i_host_lock(host_lock),
    .o_host_gnt(host_gnt), .o_host_rvalid(host_rvalid), .o_host_rdata(host_rdata),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_byte_en(mem_be),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .o_owner(owner), .o_conflict_cnt(conflict)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_addr = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_lock = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; idle_inputs();
    @(negedge clk);
    @(negedge clk); rst = 0;
  endtask

  typedef struct {
    logic rst; logic creq, cwe; logic [15:0] caddr;
    logic hreq, hwe; logic [15:0] haddr; logic [31:0] mrd;
    logic egc, egh, ecv, ehv, ewe; logic [15:0] eaddr; logic [31:0] erd;
    logic [1:0] eown; logic [15:0] ecnf;
  } vec_t;

  vec_t vt[14];

  initial begin
    // rst creq cwe caddr  hreq hwe haddr  mrd | gc gh cv hv we eaddr erd own cnf
    vt[0]  = '{1,1,0,16'h0010, 0,0,16'h0000, 32'h0,        0,0,0,0,0,16'h0000,32'h0,        2'b00,16'd0};
    vt[1]  = '{0,1,0,16'h0010, 0,0,16'h0000, 32'hDEAD0000, 1,0,0,0,0,16'h0010,32'h0,        2'b00,16'd0};
    vt[2]  = '{0,0,0,16'h0000, 0,0,16'h0000, 32'hA1B2C3D4, 0,0,1,0,0,16'h0000,32'hA1B2C3D4, 2'b01,16'd0};
    vt[3]  = '{0,1,0,16'h0001, 0,0,16'h0000, 32'h0,        1,0,0,0,0,16'h0001,32'h0,        2'b00,16'd0};
    vt[4]  = '{0,0,0,16'h0000, 1,0,16'h0002, 32'h11110001, 0,1,1,0,0,16'h0002,32'h11110001, 2'b01,16'd0};
    vt[5]  = '{0,1,0,16'h0003, 0,0,16'h0000, 32'h22220002, 1,0,0,1,0,16'h0003,32'h22220002, 2'b10,16'd0};
    vt[6]  = '{0,0,0,16'h0000, 0,0,16'h0000, 32'h33330003, 0,0,1,0,0,16'h0000,32'h33330003, 2'b01,16'd0};
    vt[7]  = '{0,1,1,16'h0020, 0,0,16'h0000, 32'h0,        1,0,0,0,1,16'h0020,32'h0,        2'b00,16'd0};
    vt[8]  = '{0,0,0,16'h0000, 0,0,16'h0000, 32'h44,       0,0,0,0,0,16'h0000,32'h0,        2'b01,16'd0};
    vt[9]  = '{0,0,0,16'h0000, 1,0,16'h0030, 32'h0,        0,1,0,0,0,16'h0030,32'h0,        2'b00,16'd0};
    vt[10] = '{1,0,0,16'h0000, 0,0,16'h0000, 32'h55555555, 0,0,0,0,0,16'h0000,32'h0,        2'b00,16'd0};
    vt[11] = '{0,0,0,16'h0000, 0,0,16'h0000, 32'h5A5A5A5A, 0,0,0,0,0,16'h0000,32'h0,        2'b00,16'd0};
    vt[12] = '{0,1,0,16'h0040, 1,0,16'h0050, 32'h0,        1,0,0,0,0,16'h0040,32'h0,        2'b00,16'd0};
    vt[13] = '{0,0,0,16'h0000, 0,0,16'h0000, 32'h66666666, 0,0,1,0,0,16'h0000,32'h66666666, 2'b01,16'd1};

    rst = 1; idle_inputs();
    core_be = CBE; core_wdata = CWD;
    host_be = 4'h3; host_wdata = 32'h03030303;
    mem_rdata = '0;
    repeat (2) @(negedge clk);

    // Table: single transactions, alternating reads, write, read cut by reset
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst = vt[i].rst;
      core_req = vt[i].creq; core_we = vt[i].cwe; core_addr = vt[i].caddr;
      host_req = vt[i].hreq; host_we = vt[i].hwe; host_addr = vt[i].haddr;
      mem_rdata = vt[i].mrd;
      #1;
      chk($sformatf("v%0d core_gnt", i), 32'(core_gnt), 32'(vt[i].egc));
      chk($sformatf("v%0d host_gnt", i), 32'(host_gnt), 32'(vt[i].egh));
      chk($sformatf("v%0d core_rvalid", i), 32'(core_rvalid), 32'(vt[i].ecv));
      chk($sformatf("v%0d host_rvalid", i), 32'(host_rvalid), 32'(vt[i].ehv));
      chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vt[i].ewe));
      chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vt[i].eaddr));
      chk($sformatf("v%0d mem_be", i), 32'(mem_be),
          32'(vt[i].egc ? CBE : vt[i].egh ? 4'h3 : 4'h0));
      chk($sformatf("v%0d mem_wdata", i), mem_wdata,
          vt[i].egc ? CWD : vt[i].egh ? 32'h03030303 : 32'h0);
      chk($sformatf("v%0d owner", i), 32'(owner), 32'(vt[i].eown));
      chk($sformatf("v%0d conflict", i), 32'(conflict), 32'(vt[i].ecnf));
      if (vt[i].ecv) chk($sformatf("v%0d core_rdata", i), core_rdata, vt[i].erd);
      if (vt[i].ehv) chk($sformatf("v%0d host_rdata", i), host_rdata, vt[i].erd);
    end

    // Both request continuously: CORE x4, HOST x4, CORE x4
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      core_req = 1; core_addr = 16'h0100; host_req = 1; host_addr = 16'h0200;
      #1;
      chk($sformatf("burst%0d core_gnt", i), 32'(core_gnt), 32'(((i / 4) % 2) == 0));
      chk($sformatf("burst%0d host_gnt", i), 32'(host_gnt), 32'(((i / 4) % 2) == 1));
      chk($sformatf("burst%0d owner", i), 32'(owner),
          (i == 0) ? 32'd0 : ((((i - 1) / 4) % 2) == 0) ? 32'd1 : 32'd2);
      chk($sformatf("burst%0d conflict", i), 32'(conflict), 32'(i));
    end

    // Host lock write holds the port against a waiting core for 10 cycles
    do_reset();
    host_be = 4'b0100; host_wdata = 32'h00FF0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      core_req = 1; core_addr = 16'h0077;
      host_req = 1; host_we = 1; host_lock = 1; host_addr = 16'h4000;
      #1;
      chk($sformatf("lock%0d host_gnt", i), 32'(host_gnt), 32'd1);
      chk($sformatf("lock%0d core_gnt", i), 32'(core_gnt), 32'd0);
      chk($sformatf("lock%0d mem_we", i), 32'(mem_we), 32'd1);
      chk($sformatf("lock%0d mem_addr", i), 32'(mem_addr), 32'h4000);
      chk($sformatf("lock%0d mem_be", i), 32'(mem_be), 32'h4);
      chk($sformatf("lock%0d mem_wdata", i), mem_wdata, 32'h00FF0000);
      chk($sformatf("lock%0d conflict", i), 32'(conflict), 32'(i));
    end
    @(negedge clk); idle_inputs();
    #1;
    chk("lock conflict total", 32'(conflict), 32'd10);
    chk("lock no host_rvalid", 32'(host_rvalid), 32'd0);

    // Counter saturation: preload 0xFFFE, then three refused cycles
    force dut.conflict_q = 16'hFFFE;
    @(negedge clk);
    release dut.conflict_q;
    core_req = 1; host_req = 1; host_lock = 1; host_we = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("sat%0d conflict", i), 32'(conflict), 32'hFFFF);
    end
    @(negedge clk); idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
